// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART frame layout, entry format and parity-mode encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int START_BIT  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;
  localparam int FRAME_W    = 11;
  localparam int ENTRY_W    = 10;

  typedef enum logic {
    PARITY_EVEN     = 1'b0,
    PARITY_MODE_ODD = 1'b1
  } parity_mode_e;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic frame_err(input logic [FRAME_W-1:0] f);
    return (f[START_BIT] != 1'b0) || (f[STOP_BIT] != 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock FIFO, registered write/pop, combinational head.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd = rd_en && !empty;
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign level   = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer
// Brief    : Checks and strips UART framing, buffers bytes for the host.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          baud_clk,
  input  logic                          rst_n,
  input  logic                          recieved_flag,
  input  logic [FRAME_W-1:0]            data_parll,
  output logic [7:0]                    rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun_err,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam parity_mode_e C_PARITY_MODE = PARITY_ODD ? PARITY_MODE_ODD : PARITY_EVEN;

  logic               r_flag_q;
  logic [FRAME_W-1:0] r_frame;
  logic               r_pend;
  logic               r_overrun;
  logic               w_capture;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  logic               w_overrun_set;
  rx_entry_t          w_entry;
  rx_entry_t          w_head;

  assign w_capture = recieved_flag && !r_flag_q;
  assign w_pop     = rx_valid && rx_ready;

  always_comb begin
    w_entry      = '0;
    w_entry.data = r_frame[DATA_MSB:DATA_LSB];
    w_entry.ferr = frame_err(r_frame);
    w_entry.perr = PARITY_EN &&
                   ((^r_frame[PARITY_BIT:DATA_LSB]) != logic'(C_PARITY_MODE));
  end

  // A pop in the same cycle frees the slot, so only an unpopped full FIFO drops.
  assign w_overrun_set = r_pend && w_fifo_full && !w_pop;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_q  <= 1'b0;
      r_frame   <= '0;
      r_pend    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_flag_q <= recieved_flag;
      r_pend   <= w_capture;
      if (w_capture) begin
        r_frame <= data_parll;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (baud_clk),
    .rst_n   (rst_n),
    .wr_en   (r_pend),
    .wr_data (w_entry),
    .full    (w_fifo_full),
    .rd_en   (rx_ready),
    .rd_data (w_head),
    .empty   (w_fifo_empty),
    .level   (fifo_level)
  );

  assign rx_valid      = !w_fifo_empty;
  assign rx_data       = w_head.data;
  assign rx_parity_err = w_head.perr;
  assign rx_frame_err  = w_head.ferr;
  assign overrun_err   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deframer
// Brief    : Directed and randomized bench with a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deframer;

  localparam int DEPTH = 4;

  logic        baud_clk = 1'b0;
  logic        rst_n;
  logic        recieved_flag;
  logic [10:0] data_parll;
  logic        rx_ready;
  logic        err_clr;

  logic [7:0]  rx_data,       np_rx_data;
  logic        rx_parity_err, np_rx_parity_err;
  logic        rx_frame_err,  np_rx_frame_err;
  logic        rx_valid,      np_rx_valid;
  logic        overrun_err,   np_overrun_err;
  logic [2:0]  fifo_level,    np_fifo_level;

  int checks = 0;
  int errors = 0;
  bit rnd    = 1'b0;

  always #5 baud_clk = ~baud_clk;

  uart_rx_deframer #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0), .FIFO_DEPTH(DEPTH)) dut (
    .baud_clk(baud_clk), .rst_n(rst_n), .recieved_flag(recieved_flag),
    .data_parll(data_parll), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun_err(overrun_err), .err_clr(err_clr), .fifo_level(fifo_level)
  );

  uart_rx_deframer #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0), .FIFO_DEPTH(DEPTH)) dut_np (
    .baud_clk(baud_clk), .rst_n(rst_n), .recieved_flag(recieved_flag),
    .data_parll(data_parll), .rx_data(np_rx_data), .rx_parity_err(np_rx_parity_err),
    .rx_frame_err(np_rx_frame_err), .rx_valid(np_rx_valid), .rx_ready(rx_ready),
    .overrun_err(np_overrun_err), .err_clr(err_clr), .fifo_level(np_fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the FIFO holds whole frames; entries are derived on read.
  logic [10:0] mq[$];
  logic [10:0] m_frame;
  bit          m_pend, m_flag_prev, m_ov;
  int          m_sz;
  bit          m_pop, m_set;

  function automatic logic [9:0] model_entry(input logic [10:0] f, input bit par_en);
    int ones = $countones(f[9:1]);
    bit perr = par_en && (ones % 2 == 1);
    bit ferr = (f[0] == 1'b1) || (f[10] == 1'b0);
    return {perr, ferr, f[8:1]};
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  always @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pend = 0; m_flag_prev = 0; m_ov = 0; m_frame = '0;
    end else begin
      m_sz  = mq.size();
      m_pop = (m_sz != 0) && rx_ready;
      m_set = 0;
      if (m_pop) void'(mq.pop_front());
      if (m_pend) begin
        if (m_sz == DEPTH && !m_pop) m_set = 1;
        else mq.push_back(m_frame);
      end
      m_ov = m_set ? 1'b1 : (err_clr ? 1'b0 : m_ov);
      m_pend = recieved_flag && !m_flag_prev;
      if (m_pend) m_frame = data_parll;
      m_flag_prev = recieved_flag;
    end
  end

  logic [9:0] e_p, e_np;
  always @(negedge baud_clk) begin
    check("valid",   rx_valid,       mq.size() != 0);
    check("level",   fifo_level,     mq.size());
    check("overrun", overrun_err,    m_ov);
    check("np_valid",   np_rx_valid,    mq.size() != 0);
    check("np_level",   np_fifo_level,  mq.size());
    check("np_overrun", np_overrun_err, m_ov);
    if (mq.size() != 0) begin
      e_p  = model_entry(mq[0], 1'b1);
      e_np = model_entry(mq[0], 1'b0);
      check("data",    rx_data,          e_p[7:0]);
      check("ferr",    rx_frame_err,     e_p[8]);
      check("perr",    rx_parity_err,    e_p[9]);
      check("np_data", np_rx_data,       e_np[7:0]);
      check("np_ferr", np_rx_frame_err,  e_np[8]);
      check("np_perr", np_rx_parity_err, e_np[9]);
    end
  end

  task automatic tick();
    @(posedge baud_clk);
    #1;
    if (rnd) begin
      rx_ready = ($urandom_range(0, 1) == 1);
      err_clr  = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic send(input logic [10:0] f, input int hold);
    data_parll    = f;
    recieved_flag = 1'b1;
    repeat (hold) tick();
    recieved_flag = 1'b0;
    tick();
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic [10:0] f;

  initial begin
    rst_n = 1'b0; recieved_flag = 1'b0; data_parll = '0; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge baud_clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data",  rx_data, 0);
    check("rst_perr",  rx_parity_err, 0);
    check("rst_ferr",  rx_frame_err, 0);
    check("rst_ov",    overrun_err, 0);
    check("rst_level", fifo_level, 0);
    tick(); rst_n = 1'b1; tick(); tick();

    // Clean frame, flag held two cycles; valid appears two edges after the rise.
    data_parll = 11'h4AA; recieved_flag = 1'b1;
    tick();
    check("lat_edge1_valid", rx_valid, 0);
    tick(); recieved_flag = 1'b0;
    check("lat_edge2_valid", rx_valid, 1);
    check("t1_data", rx_data, 8'h55);
    check("t1_perr", rx_parity_err, 0);
    check("t1_ferr", rx_frame_err, 0);
    repeat (3) tick();
    check("t1_one_entry", fifo_level, 1);
    pop();
    check("t1_empty", rx_valid, 0);

    send(11'h6AA, 1);
    check("t2_data", rx_data, 8'h55);
    check("t2_perr", rx_parity_err, 1);
    check("t2_np_perr", np_rx_parity_err, 0);
    pop();

    send(11'h0AA, 1);
    check("t3a_data", rx_data, 8'h55);
    check("t3a_ferr", rx_frame_err, 1);
    pop();
    send(11'h4AB, 1);
    check("t3b_data", rx_data, 8'h55);
    check("t3b_ferr", rx_frame_err, 1);
    pop();

    // Five frames into a four-deep buffer: the fifth is dropped.
    for (int b = 1; b <= 5; b++) send(mk(8'(b)), 1);
    check("t4_level", fifo_level, 4);
    check("t4_ov", overrun_err, 1);
    for (int b = 1; b <= 4; b++) begin
      check("t4_order", rx_data, b);
      pop();
    end
    check("t4_drained", rx_valid, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t4_clr", overrun_err, 0);

    // Full buffer, push coincident with pop.
    for (int b = 8'h11; b <= 8'h14; b++) send(mk(8'(b)), 1);
    data_parll = mk(8'h15); recieved_flag = 1'b1;
    tick();
    rx_ready = 1'b1; recieved_flag = 1'b0;
    tick();
    rx_ready = 1'b0;
    check("t5_level", fifo_level, 4);
    check("t5_ov", overrun_err, 0);
    for (int b = 8'h12; b <= 8'h15; b++) begin
      check("t5_order", rx_data, b);
      pop();
    end

    // Reset one cycle after capture discards the pending frame.
    data_parll = 11'h4AA; recieved_flag = 1'b1;
    tick();
    rst_n = 1'b0; recieved_flag = 1'b0;
    tick();
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_level", fifo_level, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_no_entry", fifo_level, 0);
    check("t6_ov", overrun_err, 0);

    // Flag already high when reset releases captures exactly once.
    data_parll = mk(8'h20); recieved_flag = 1'b1; rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    repeat (4) tick();
    recieved_flag = 1'b0; tick();
    check("t7_one_capture", fifo_level, 1);
    check("t7_data", rx_data, 8'h20);

    // Overrun coincident with err_clr: set wins.
    for (int b = 8'h21; b <= 8'h23; b++) send(mk(8'(b)), 1);
    data_parll = mk(8'h24); recieved_flag = 1'b1;
    tick();
    err_clr = 1'b1; recieved_flag = 1'b0;
    tick();
    err_clr = 1'b0;
    check("t8_ov_set_wins", overrun_err, 1);
    check("t8_level", fifo_level, 4);

    rnd = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      f = mk(r[7:0]);
      if (r[11:8] == 0)  f[9]  = ~f[9];
      if (r[15:12] == 0) f[0]  = 1'b1;
      if (r[19:16] == 0) f[10] = 1'b0;
      send(f, $urandom_range(1, 3));
      repeat ($urandom_range(0, 4)) tick();
    end
    rnd = 1'b0; rx_ready = 1'b1; err_clr = 1'b0;
    repeat (10) tick();
    check("final_empty", rx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Sits directly downstream of the UART RX serial-to-parallel stage, in the baud_clk domain.
- Consumes the 11-bit frame word and its completion flag.
- Checks start, parity and stop bits, then strips framing.
- Buffers bytes in a small FIFO and presents them on a valid/ready interface to the host side, with per-byte and sticky error status.

Parameters:
PARITY_EN, 1, 1 = bit 9 is checked as parity; 0 = bit 9 ignored, parity_err never set
PARITY_ODD, 0, 0 = even parity, 1 = odd parity
FIFO_DEPTH, 4, entries in the byte buffer; power of 2, minimum 2

Ports:
baud_clk  in  1  oversampling baud clock; sole clock
rst_n  in  1  asynchronous active-low reset
recieved_flag  in  1  high while the frame word is complete; high for 1 or more consecutive cycles per frame
data_parll  in  11  frame word: [0]=start, [8:1]=data LSB-first, [9]=parity, [10]=stop
rx_data  out  8  head-of-FIFO byte
rx_parity_err  out  1  parity error flag of the head entry
rx_frame_err  out  1  frame error flag of the head entry
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts the head entry when rx_valid & rx_ready
overrun_err  out  1  sticky: a frame was dropped because the FIFO was full
err_clr  in  1  clears overrun_err
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- Reset: all registers clear asynchronously.
  - rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, overrun_err=0, fifo_level=0.
  - flag_q=0, FIFO pointers=0.
- Edge detect: flag_q registers recieved_flag. A capture event is recieved_flag & ~flag_q.
  - Exactly one capture per frame, regardless of how long the flag stays high.
  - A flag already high out of reset captures once (flag_q resets to 0).
- Cycle N (capture event): data_parll is latched into frame_r and pend is set.
- Cycle N+1 (check/push), combinational from frame_r:
  - ferr = (frame_r[0] != 0) | (frame_r[10] != 1).
  - perr = PARITY_EN & ((^frame_r[9:1]) != PARITY_ODD).
  - Entry {perr, ferr, frame_r[8:1]} is written; pend clears.
- Latency: with an empty FIFO, rx_valid rises at the first clock edge after the push, i.e. 2 cycles after the capture edge.
- Errored bytes are still pushed, tagged with their error flags; the consumer decides what to discard.
- FIFO:
  - Synchronous write and pop; head data is combinational from storage at the read pointer.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits. Full/empty are derived from MSB comparison and wrap naturally.
- Pop: occurs when rx_valid & rx_ready. rx_ready while empty has no effect.
- Simultaneous push and pop:
  - When full: both happen, level is unchanged, no overrun.
  - When empty: the push lands, the pop is not possible, and rx_valid rises next cycle.
- Overrun: a push while full with no pop in the same cycle drops the new entry and sets overrun_err. Existing entries are untouched.
- err_clr: clears overrun_err next cycle. If err_clr coincides with a new overrun, set wins.
- A capture event while pend is still set cannot occur, because frames are at least 11 bit-times apart. No queueing is required beyond frame_r.
- Reset mid-operation: a pending frame and all FIFO contents are discarded.
- rx_data / err flags hold stable while rx_valid & ~rx_ready.

Decomposition:
- Shared package uart_pkg:
  - Frame bit-position constants: START_BIT=0, DATA_LSB=1, DATA_MSB=8, PARITY_BIT=9, STOP_BIT=10, FRAME_W=11.
  - Entry width constant ENTRY_W=10.
  - Parity-mode encoding.
- One sub-module, uart_sync_fifo:
  - Parameters: width and depth.
  - Signals: wr_en/wr_data/full, rd_en/rd_data/empty, level.
  - Reusable by the TX path.

Test Plan:
- Frame 0x4AA (byte 0x55, even parity 0, stop 1), flag high 2 cycles -> exactly one entry, rx_data=0x55, perr=0, ferr=0, rx_valid high 2 cycles after capture edge.
- Frame 0x6AA (parity bit flipped), PARITY_EN=1 -> rx_data=0x55, rx_parity_err=1. Same frame with PARITY_EN=0 -> rx_parity_err=0.
- Frame 0x0AA (stop=0) and frame 0x4AB (start=1) -> rx_frame_err=1 for each, data 0x55 still delivered.
- rx_ready=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4 -> fifo_level=4, overrun_err=1, pops yield 0x01..0x04, 0x05 is lost.
- FIFO full, capture push coincides with a pop -> level stays 4, overrun_err stays 0, order preserved.
- Assert rst_n low one cycle after a capture edge -> no entry appears, all outputs 0. Then err_clr coincident with an overrun -> overrun_err remains 1.
